// File: rtl/div_unit_pkg.sv
// Shared definitions for the EX-stage divider: FSM state encodings and control constants.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic        RstEnable         = 1'b1;
  localparam logic [31:0] ZeroWord          = 32'h0000_0000;
  localparam logic        DivResultReady    = 1'b1;
  localparam logic        DivResultNotReady = 1'b0;
  localparam logic        DivStart          = 1'b1;
  localparam logic        DivStop           = 1'b0;

endpackage

// File: rtl/div_abs.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign fixup.
module div_abs #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] value,
  output logic [W-1:0] result
);

  assign result = neg ? (~value + W'(1)) : value;

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider (DIV/DIVU), one quotient bit per cycle.
// Define DIV_EARLY_OUT_EN to finish in one cycle when |dividend| < |divisor|.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                annul_i,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  localparam logic [CNT_W-1:0] DoneCnt = CNT_W'(DATA_W);

  div_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] dvd_q;   // dividend magnitude, shifted into the quotient
  logic [DATA_W-1:0] dvs_q;
  logic [DATA_W-1:0] rem_q;
  logic              sign1_q, sign2_q, signed_q;

  logic              neg1, neg2;
  logic [DATA_W-1:0] op1_abs, op2_abs;

  assign neg1 = signed_div_i & opdata1_i[DATA_W-1];
  assign neg2 = signed_div_i & opdata2_i[DATA_W-1];

  div_abs #(.W(DATA_W)) u_abs_op1 (.neg(neg1), .value(opdata1_i), .result(op1_abs));
  div_abs #(.W(DATA_W)) u_abs_op2 (.neg(neg2), .value(opdata2_i), .result(op2_abs));

  // One restoring step: shift the next dividend bit into the remainder and trial-subtract.
  logic [DATA_W:0]   rem_shift, trial;
  logic              q_bit;
  logic [DATA_W-1:0] rem_next, quo_next;

  assign rem_shift = {rem_q, dvd_q[DATA_W-1]};
  assign trial     = rem_shift - {1'b0, dvs_q};
  assign q_bit     = ~trial[DATA_W];
  assign rem_next  = q_bit ? trial[DATA_W-1:0] : rem_shift[DATA_W-1:0];
  assign quo_next  = {dvd_q[DATA_W-2:0], q_bit};

  logic              neg_quo, neg_rem;
  logic [DATA_W-1:0] quo_fix, rem_fix;

  assign neg_quo = signed_q & (sign1_q ^ sign2_q);
  assign neg_rem = signed_q & sign1_q;

  div_abs #(.W(DATA_W)) u_fix_quo (.neg(neg_quo), .value(dvd_q), .result(quo_fix));
  div_abs #(.W(DATA_W)) u_fix_rem (.neg(neg_rem), .value(rem_q), .result(rem_fix));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state    <= DivFree;
      cnt      <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      signed_q <= 1'b0;
      ready_o  <= DivResultNotReady;
      result_o <= '0;
    end else begin
      case (state)
        DivFree: begin
          if (start_i == DivStart && !annul_i) begin
            if (opdata2_i == ZeroWord) begin
              state <= DivByZero;
`ifdef DIV_EARLY_OUT_EN
            end else if (op1_abs < op2_abs) begin
              state    <= DivEnd;
              ready_o  <= DivResultReady;
              result_o <= {opdata1_i, ZeroWord};
`endif
            end else begin
              state    <= DivOn;
              cnt      <= '0;
              rem_q    <= '0;
              dvd_q    <= op1_abs;
              dvs_q    <= op2_abs;
              sign1_q  <= opdata1_i[DATA_W-1];
              sign2_q  <= opdata2_i[DATA_W-1];
              signed_q <= signed_div_i;
            end
          end
        end

        DivByZero: begin
          state    <= DivEnd;
          ready_o  <= DivResultReady;
          result_o <= '0;
        end

        DivOn: begin
          if (annul_i) begin
            state    <= DivFree;
            ready_o  <= DivResultNotReady;
            result_o <= '0;
          end else if (cnt == DoneCnt) begin
            state    <= DivEnd;
            ready_o  <= DivResultReady;
            result_o <= {rem_fix, quo_fix};
          end else begin
            dvd_q <= quo_next;
            rem_q <= rem_next;
            cnt   <= cnt + CNT_W'(1);
          end
        end

        DivEnd: begin
          // Result is held until EX drops its request or the pipeline is flushed.
          if (annul_i || start_i == DivStop) begin
            state    <= DivFree;
            ready_o  <= DivResultNotReady;
            result_o <= '0;
          end
        end

        default: state <= DivFree;
      endcase
    end
  end

endmodule
